// File: rtl/status_pkg.sv
// Shared constants and types for the EXE-stage status flag stack.
package status_pkg;

    localparam int STATUS_FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [STATUS_FLAG_W-1:0] flags_t;

endpackage

// File: rtl/status_lifo.sv
// Parametrised LIFO of saved flag words with push, pop and in-place swap of the top entry.
// The caller guarantees the operations are legal (no push when full, no pop/swap when empty).
module status_lifo #(
    parameter int FLAG_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               swap,
    input  logic [FLAG_W-1:0]  wdata,
    output logic [FLAG_W-1:0]  top_data,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [FLAG_W-1:0]  mem_r [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_r;
    logic [DEPTH_W-1:0] depth_nxt_s;
    logic               full_r;
    logic               empty_r;
    logic [IDX_W-1:0]   push_idx_s;
    logic [IDX_W-1:0]   top_idx_s;

    // Index and next-occupancy decode
    always_comb begin
        push_idx_s  = IDX_W'(depth_r);
        top_idx_s   = IDX_W'(depth_r - DEPTH_W'(1));
        depth_nxt_s = depth_r;
        if (push) begin
            depth_nxt_s = depth_r + DEPTH_W'(1);
        end else if (pop) begin
            depth_nxt_s = depth_r - DEPTH_W'(1);
        end else begin
            depth_nxt_s = depth_r;
        end
    end

    // Occupancy count with registered full/empty kept in step with it
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_r <= {DEPTH_W{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            depth_r <= depth_nxt_s;
            full_r  <= (depth_nxt_s == DEPTH_W'(STACK_DEPTH));
            empty_r <= (depth_nxt_s == {DEPTH_W{1'b0}});
        end
    end

    // Storage is not reset; entries beyond depth are never read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[push_idx_s] <= wdata;
        end else if (swap) begin
            mem_r[top_idx_s] <= wdata;
        end
    end

    // Top-of-stack read, forced to zero when nothing is stored
    always_comb begin
        if (empty_r) begin
            top_data = {FLAG_W{1'b0}};
        end else begin
            top_data = mem_r[top_idx_s];
        end
    end

    assign depth = depth_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/status_stack_reg.sv
// Live NZCV-style status register with masked writes, zero-latency forwarding and a save/restore stack.
// Define STATUS_STACK_TRACE_EN to enable a simulation-only trace of flag writes and stack events.
module status_stack_reg
    import status_pkg::*;
#(
    parameter int FLAG_W      = STATUS_FLAG_W,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLAG_W-1:0]  status_bits_in,
    input  logic               s,
    input  logic [FLAG_W-1:0]  wr_mask,
    input  logic               push,
    input  logic               pop,
    input  logic               err_clr,
    output logic [FLAG_W-1:0]  status_bits_out,
    output logic [FLAG_W-1:0]  flags_fwd,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic               ovf_err,
    output logic               unf_err
);

    logic [FLAG_W-1:0] flags_r;
    logic [FLAG_W-1:0] flags_nxt_s;
    logic [FLAG_W-1:0] wval_s;
    logic [FLAG_W-1:0] top_s;
    logic              full_s;
    logic              empty_s;
    logic              push_acc_s;
    logic              pop_acc_s;
    logic              swap_s;
    logic              take_top_s;
    logic              ovf_ev_s;
    logic              unf_ev_s;
    logic              ovf_r;
    logic              unf_r;

    // Operation decode; push+pop on an empty stack degrades to a plain push
    always_comb begin
        wval_s     = (flags_r & ~wr_mask) | (status_bits_in & wr_mask);
        swap_s     = push && pop && !empty_s;
        pop_acc_s  = pop && !push && !empty_s;
        push_acc_s = push && (!pop || empty_s) && !full_s;
        ovf_ev_s   = push && !pop && full_s;
        unf_ev_s   = pop && !push && empty_s;
        take_top_s = pop_acc_s || swap_s;
        if (take_top_s) begin
            flags_nxt_s = top_s;
        end else if (s) begin
            flags_nxt_s = wval_s;
        end else begin
            flags_nxt_s = flags_r;
        end
    end

    // Live flags
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= {FLAG_W{1'b0}};
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    // Sticky error bits; a same-cycle event beats err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_ev_s ? 1'b1 : (err_clr ? 1'b0 : ovf_r);
            unf_r <= unf_ev_s ? 1'b1 : (err_clr ? 1'b0 : unf_r);
        end
    end

    status_lifo #(
        .FLAG_W      (FLAG_W),
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_lifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_acc_s),
        .pop      (pop_acc_s),
        .swap     (swap_s),
        .wdata    (flags_r),
        .top_data (top_s),
        .depth    (depth),
        .full     (full_s),
        .empty    (empty_s)
    );

`ifdef STATUS_STACK_TRACE_EN
    // Simulation trace of flag writes and stack events
    always @(posedge clk) begin
        if (!rst) begin
            if (s && !take_top_s && (wval_s != flags_r)) $display("%b", wval_s);
            if (push_acc_s) $display("PUSH d=%0d", depth + 1);
            if (pop_acc_s)  $display("POP d=%0d", depth - 1);
            if (ovf_ev_s)   $display("OVF");
            if (unf_ev_s)   $display("UNF");
        end
    end
`endif

    assign status_bits_out = flags_r;
    assign flags_fwd       = rst ? {FLAG_W{1'b0}} : flags_nxt_s;
    assign full            = full_s;
    assign empty           = empty_s;
    assign ovf_err         = ovf_r;
    assign unf_err         = unf_r;

endmodule

// File: doc/status_stack_reg.md
Name: status_stack_reg

Overview:
- Parametrised successor to the EXE-stage NZCV status register.
- Holds the live condition flags, with per-bit masked writes and a same-cycle forwarding path for the next instruction.
- Adds a LIFO save/restore stack: exception/call entry saves the flags, and return restores them.
- Sits in EXE. It is fed by the ALU status output and the control unit's S bit. flags_fwd feeds the condition-check logic in ID.

Parameters:
- FLAG_W, 4, number of status bits (bit3 N, bit2 Z, bit1 C, bit0 V when 4).
- STACK_DEPTH, 4, number of saved flag entries; must be ≥ 1.
- DEPTH_W, $clog2(STACK_DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- status_bits_in  in  FLAG_W  new flag values from the ALU.
- s  in  1  flag write enable (instruction S bit).
- wr_mask  in  FLAG_W  per-bit update mask; 1 = bit takes status_bits_in.
- push  in  1  save the current flags_out onto the stack.
- pop  in  1  restore flags_out from the stack top.
- err_clr  in  1  clears the sticky error bits.
- status_bits_out  out  FLAG_W  registered live flags.
- flags_fwd  out  FLAG_W  combinational value that status_bits_out will hold after this edge.
- depth  out  DEPTH_W  number of valid stack entries.
- full  out  1  depth == STACK_DEPTH.
- empty  out  1  depth == 0.
- ovf_err  out  1  sticky: push was attempted while full.
- unf_err  out  1  sticky: pop was attempted while empty.

Behaviour:
- **Reset** (synchronous, rst high at a rising edge):
  - status_bits_out = 0, depth = 0, ovf_err = 0, unf_err = 0.
  - Stack storage is don't-care.
  - rst overrides every other input in that cycle, including a push or pop in flight.
- **Masked write:** wval = (status_bits_out & ~wr_mask) | (status_bits_in & wr_mask). s with wr_mask = 0 is a no-op.
- **Update priority per edge** (rst low):
  - pop && !push && !empty: status_bits_out <= stack[top]; depth--. s is ignored, because return wins over flag update.
  - push && !pop && !full: stack[depth] <= status_bits_out (pre-update value); depth++. If s is also high, status_bits_out <= wval.
  - push && pop && !empty (swap): stack[top] <= status_bits_out; status_bits_out <= old stack[top]; depth unchanged; s ignored.
  - push && pop && empty: treated as push only; unf_err is not set.
  - Otherwise: status_bits_out <= wval if s, else hold.
- **Error and boundary cases:**
  - push && !pop && full: push dropped, stack unchanged, ovf_err <= 1; s still applies.
  - pop && !push && empty: status_bits_out unchanged by pop, unf_err <= 1; s still applies.
  - err_clr clears both sticky bits. An error event in the same cycle wins, and the bit stays 1.
- **flags_fwd:** combinationally equals the next-state value of status_bits_out per the rules above (zero latency). status_bits_out has 1-cycle latency.
- depth, full and empty are registered and consistent with each other every cycle.

Optional Feature:
- Macro: STATUS_STACK_TRACE_EN.
- When defined, a simulation-only $display fires on every edge where status_bits_out changes via s, printing the new FLAG_W bits MSB-first with no separators, e.g. "1001".
- It also prints "PUSH d=<depth>" and "POP d=<depth>" on accepted stack operations, and "OVF"/"UNF" on errors.
- When undefined, no display statements are compiled, and RTL behaviour is identical.

Decomposition:
- **Package status_pkg:**
  - FLAG_W default constant.
  - Flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - typedef flags_t = logic [FLAG_W-1:0].
- **Sub-module status_lifo:** parametrised LIFO (storage array, depth counter, full/empty, top read, push/pop/swap).
  - The top level holds the live register, mask merge, priority decode, sticky errors and forwarding.

Test Plan:
1. Reset, then s=1, mask=1111, in=1010 → flags_fwd = 1010 same cycle; status_bits_out = 1010 next cycle.
2. out=1010, s=1, mask=0100, in=0100 → out = 1110 (only Z updated).
3. out=1110, push with s=1, in=0001, mask=1111 → stack[0] = 1110, out = 0001, depth = 1. Then pop → out = 1110, depth = 0, empty = 1.
4. STACK_DEPTH=4: five pushes → depth = 4, full = 1, ovf_err = 1, stack unchanged by the fifth. err_clr → ovf_err = 0.
5. Empty stack, pop with s=1, in=0110, mask=1111 → unf_err = 1, out = 0110, depth = 0.
6. depth=2, top=0011, out=1100, push && pop → out = 0011, top = 1100, depth = 2. rst asserted mid-sequence → out = 0, depth = 0 on the next edge.
